// File: rtl/e_alu_md.sv
// e_alu_md: E-stage ALU plus iterative mult/div owning HI/LO (divider built only when ALU_MD_DIV_EN is defined)
module e_alu_md #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         src_a,
  input  logic [WIDTH-1:0]         src_b,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [3:0]               alu_ctr,
  input  logic [3:0]               md_op,
  input  logic                     md_start,
  input  logic                     md_kill,
  output logic [WIDTH-1:0]         alu_result,
  output logic                     overflow,
  output logic [WIDTH-1:0]         md_rd_data,
  output logic                     md_busy,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo
);
  localparam int SW   = $clog2(WIDTH);
  localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  logic [WIDTH:0]         sum, dif;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       op_a, op_b;
  logic                   op_div, op_sgn;
  logic                   accept, mult_op, div_op, wr_ok;
  logic [2*WIDTH-1:0]     ext_a, ext_b, prod, res;
  assign sum = {src_a[WIDTH-1], src_a} + {src_b[WIDTH-1], src_b};
  assign dif = {src_a[WIDTH-1], src_a} - {src_b[WIDTH-1], src_b};
  always_comb begin
    case (alu_ctr)
      4'd0:    alu_result = sum[WIDTH-1:0];
      4'd1:    alu_result = dif[WIDTH-1:0];
      4'd2:    alu_result = src_a & src_b;
      4'd3:    alu_result = src_a | src_b;
      4'd4:    alu_result = src_b << (WIDTH / 2);
      4'd5:    alu_result = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'd6:    alu_result = {{(WIDTH-1){1'b0}}, src_a < src_b};
      4'd7:    alu_result = src_a ^ src_b;
      4'd8:    alu_result = ~(src_a | src_b);
      4'd9:    alu_result = src_b << shamt;
      4'd10:   alu_result = src_b >> shamt;
      4'd11:   alu_result = $signed(src_b) >>> shamt;
      4'd12:   alu_result = src_b << src_a[SW-1:0];
      4'd13:   alu_result = src_b >> src_a[SW-1:0];
      4'd14:   alu_result = $signed(src_b) >>> src_a[SW-1:0];
      default: alu_result = '0;
    endcase
  end
  assign overflow = (alu_ctr == 4'd0 && (sum[WIDTH] ^ sum[WIDTH-1])) ||
                    (alu_ctr == 4'd1 && (dif[WIDTH] ^ dif[WIDTH-1]));
  assign md_busy    = cnt != '0;
  assign accept     = md_start & ~md_kill & ~md_busy;
  assign mult_op    = md_op == 4'd1 || md_op == 4'd2;
  assign md_rd_data = md_op == 4'd5 ? hi : md_op == 4'd6 ? lo : '0;
  assign ext_a = op_sgn ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
  assign ext_b = op_sgn ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
  assign prod  = ext_a * ext_b;
`ifdef ALU_MD_DIV_EN
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] ua, ub, q, r;
  assign div_op = md_op == 4'd3 || md_op == 4'd4;
  assign a_neg  = op_sgn & op_a[WIDTH-1];
  assign b_neg  = op_sgn & op_b[WIDTH-1];
  assign ua     = a_neg ? -op_a : op_a;
  assign ub     = b_neg ? -op_b : op_b;
  assign q      = ua / ub;
  assign r      = ua % ub;
  assign res    = op_div ? {a_neg ? -r : r, (a_neg ^ b_neg) ? -q : q} : prod;
  assign wr_ok  = ~op_div | (op_b != '0);
`else
  assign div_op = 1'b0;
  assign res    = prod;
  assign wr_ok  = ~op_div;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_div <= 1'b0;
      op_sgn <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (accept && md_op == 4'd7) hi <= src_a;
      if (accept && md_op == 4'd8) lo <= src_a;
      if (accept && (mult_op || div_op)) begin
        op_a   <= src_a;
        op_b   <= src_b;
        op_div <= div_op;
        op_sgn <= md_op == 4'd1 || md_op == 4'd3;
        cnt    <= div_op ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      end else if (md_busy) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1) && wr_ok) {hi, lo} <= res;
      end
    end
  end
endmodule

// File: tb/tb_e_alu_md.sv
// tb_e_alu_md: directed and randomized checks of e_alu_md against a behavioural model
module tb_e_alu_md;
  localparam int W = 32;
  logic          clk = 1'b0;
  logic          reset, md_start, md_kill, overflow, md_busy;
  logic [W-1:0]  src_a, src_b, alu_result, md_rd_data, hi, lo, m_hi, m_lo;
  logic [4:0]    shamt;
  logic [3:0]    alu_ctr, md_op;
  logic [3:0]    ops [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
  int            errors = 0, checks = 0;
  always #5 clk = ~clk;
  e_alu_md dut (
    .clk(clk), .reset(reset), .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .alu_ctr(alu_ctr), .md_op(md_op), .md_start(md_start), .md_kill(md_kill),
    .alu_result(alu_result), .overflow(overflow), .md_rd_data(md_rd_data),
    .md_busy(md_busy), .hi(hi), .lo(lo)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [32:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    longint sa, sb, s;
    logic [31:0] r;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    ov = 1'b0;
    case (c)
      4'd0:  begin s = sa + sb; r = s[31:0]; ov = s != longint'($signed(s[31:0])); end
      4'd1:  begin s = sa - sb; r = s[31:0]; ov = s != longint'($signed(s[31:0])); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = b * 32'd65536;
      4'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  r = ({32'b0, a} < {32'b0, b}) ? 32'd1 : 32'd0;
      4'd7:  r = a ^ b;
      4'd8:  r = ~(a | b);
      4'd9:  r = b << sh;
      4'd10: r = b >> sh;
      4'd11: r = 32'(sb >>> sh);
      4'd12: r = b << a[4:0];
      4'd13: r = b >> a[4:0];
      4'd14: r = 32'(sb >>> a[4:0]);
      default: r = 32'd0;
    endcase
    return {ov, r};
  endfunction
  task automatic md_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    longint sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 0;
    case (op)
      4'd1: begin {m_hi, m_lo} = 64'(sa * sb); lat = 5; end
      4'd2: begin {m_hi, m_lo} = {32'b0, a} * {32'b0, b}; lat = 5; end
`ifdef ALU_MD_DIV_EN
      4'd3: begin lat = 10; if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end end
      4'd4: begin lat = 10; if (b != 0) begin m_lo = a / b; m_hi = a % b; end end
`endif
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: lat = 0;
    endcase
  endtask
  task automatic alu_chk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    logic [32:0] e;
    alu_ctr = c; src_a = a; src_b = b; shamt = sh;
    #1;
    e = alu_ref(c, a, b, sh);
    chk($sformatf("alu%0d_res", c), 64'(alu_result), 64'(e[31:0]));
    chk($sformatf("alu%0d_ovf", c), 64'(overflow), 64'(e[32]));
  endtask
  task automatic alu_dir(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] er, input logic eo);
    alu_ctr = c; src_a = a; src_b = b; shamt = sh;
    #1;
    chk({tag, "_res"}, 64'(alu_result), 64'(er));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
  endtask
  task automatic md_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit spam, input string tag);
    int lat;
    logic [31:0] oh, ol;
    oh = m_hi; ol = m_lo;
    md_op = op; src_a = a; src_b = b; md_start = 1'b1; md_kill = 1'b0;
    md_ref(op, a, b, lat);
    @(posedge clk); #1;
    md_start = 1'b0; md_op = 4'd0;
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_busy"}, 64'(md_busy), 64'd1);
      chk({tag, "_hold"}, {hi, lo}, {oh, ol});
      if (spam && i < lat - 1) begin
        md_start = 1'b1; md_kill = 1'b1; md_op = 4'd1; src_a = $urandom; src_b = $urandom;
      end else begin
        md_start = 1'b0; md_kill = 1'b0; md_op = 4'd0;
      end
      @(posedge clk); #1;
    end
    md_start = 1'b0; md_kill = 1'b0; md_op = 4'd0;
    chk({tag, "_idle"}, 64'(md_busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask
  initial begin
    reset = 1'b1; md_start = 1'b0; md_kill = 1'b0; md_op = 4'd0;
    src_a = '0; src_b = '0; shamt = '0; alu_ctr = 4'd0; m_hi = '0; m_lo = '0;
    #1;
    chk("rst_busy", 64'(md_busy), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_rd", 64'(md_rd_data), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    alu_dir("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1);
    alu_dir("sub_ovf", 4'd1, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b1);
    alu_dir("sltu", 4'd6, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h1, 1'b0);
    alu_dir("slt", 4'd5, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0);
    alu_dir("or", 4'd3, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b0);
    alu_dir("sra", 4'd11, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0);
    alu_dir("srlv", 4'd13, 32'd36, 32'h80000000, 5'd0, 32'h08000000, 1'b0);
    alu_dir("lui", 4'd4, 32'h0, 32'h1234, 5'd0, 32'h12340000, 1'b0);
    alu_dir("zero", 4'd15, 32'h5, 32'h6, 5'd3, 32'h0, 1'b0);
    alu_dir("add_wrap", 4'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 60; i++)
      alu_chk(4'($urandom), $urandom, (i % 4 == 0) ? 32'(i) : $urandom, 5'($urandom));
    @(posedge clk); #1;
    md_issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, "mult");
    chk("mult_hi_k", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo_k", 64'(lo), 64'hFFFFFFFA);
    md_issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, "multu");
    chk("multu_hi_k", 64'(hi), 64'h1);
    chk("multu_lo_k", 64'(lo), 64'hFFFFFFFE);
    md_issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, "div");
`ifdef ALU_MD_DIV_EN
    chk("div_lo_k", 64'(lo), 64'hFFFFFFFD);
    chk("div_hi_k", 64'(hi), 64'hFFFFFFFF);
`endif
    md_issue(4'd4, 32'd5, 32'd0, 1'b0, "divu0");
    md_start = 1'b1; md_kill = 1'b1; md_op = 4'd1; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    md_start = 1'b0; md_kill = 1'b0; md_op = 4'd0;
    chk("kill_busy", 64'(md_busy), 64'd0);
    chk("kill_hilo", {hi, lo}, {m_hi, m_lo});
    md_issue(4'd7, 32'h1234, 32'd0, 1'b0, "mthi");
    md_op = 4'd5; #1;
    chk("mfhi", 64'(md_rd_data), 64'h1234);
    md_op = 4'd6; #1;
    chk("mflo", 64'(md_rd_data), 64'(m_lo));
    md_op = 4'd0; #1;
    chk("rd_none", 64'(md_rd_data), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++)
      md_issue(ops[$urandom_range(0, 5)], $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom, 1'b0, "rnd");
    md_issue(4'd8, 32'hCAFE, 32'd0, 1'b0, "mtlo");
    md_op = 4'd1; md_start = 1'b1; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    md_start = 1'b0; md_op = 4'd0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1; #1;
    m_hi = '0; m_lo = '0;
    chk("rst_mid_busy", 64'(md_busy), 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("rst_after_busy", 64'(md_busy), 64'd0);
    chk("rst_after_hilo", {hi, lo}, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
